// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit: addresses, masks,
// cause codes, privilege encodings and the interrupt priority order.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
  localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_MASK  = 32'h8000_001F;
  localparam logic [31:0] MISA_VAL     = 32'h0000_0000;

  localparam logic [4:0] CAUSE_ECALL_U = 5'd8;
  localparam logic [4:0] CAUSE_ECALL_S = 5'd9;
  localparam logic [4:0] CAUSE_ECALL_M = 5'd11;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_IRQ,
    EV_MRET
  } event_e;

  // MPP only holds U or M; any other written encoding collapses to U.
  function automatic logic [31:0] mstatus_legalize(input logic [31:0] wdata);
    logic [31:0] v;
    v = wdata & MSTATUS_MASK;
    if (wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] != PRIV_M)
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    return v;
  endfunction

  function automatic logic [4:0] ecall_cause(input logic [1:0] priv);
    case (priv)
      PRIV_U:  return CAUSE_ECALL_U;
      PRIV_S:  return CAUSE_ECALL_S;
      default: return CAUSE_ECALL_M;
    endcase
  endfunction

  // Priority among enabled pending lines: MEI > MSI > MTI.
  function automatic logic [4:0] irq_code(input logic [31:0] pend);
    if (pend[IRQ_MEI])      return IRQ_MEI;
    else if (pend[IRQ_MSI]) return IRQ_MSI;
    else                    return IRQ_MTI;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independent 32-bit half loads.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q, cnt_d;

  // A load of either half suppresses the increment for the whole counter.
  always_comb begin
    cnt_d = cnt_q;
    if (wen_lo || wen_hi) begin
      if (wen_lo) cnt_d[31:0]  = wdata;
      if (wen_hi) cnt_d[63:32] = wdata;
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: counters, interrupt arbitration,
// trap entry / mret state updates and a registered one-cycle fetch redirect.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned NUM_HPM     = 4,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_wen,
  input  logic [11:0]        csr_waddr,
  input  logic [31:0]        csr_wdata,
  input  logic               csr_ren,
  input  logic [11:0]        csr_raddr,
  output logic [31:0]        csr_rdata,
  output logic [31:0]        csr_status,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        exc_tval,
  input  logic               ecall,
  input  logic               mret,
  input  logic               irq_ext,
  input  logic               irq_soft,
  input  logic               irq_timer,
  input  logic               int_ok,
  input  logic [31:0]        int_pc,
  input  logic               instret,
  input  logic [NUM_HPM-1:0] hpm_event,
  output logic               trap_taken,
  output logic [31:0]        trap_target,
  output logic               irq_pending
);

  localparam int unsigned HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
  localparam logic [31:0] INH_MASK   = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic [31:0] mstatus_q, mstatus_d, mstatus_w;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d, mtvec_w;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mepc_w;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] minh_q, minh_d;
  logic [1:0]  priv_q, priv_d;
  logic        trap_taken_q, trap_taken_d;
  logic [31:0] trap_target_q, trap_target_d;

  logic [31:0] mip_val, pend;
  logic [63:0] cycle_val, instret_val;
  logic [63:0] hpm_val [HPM_N];
  logic [4:0]  trap_code;
  logic [31:0] tvec_base;
  event_e      ev;

  assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign pend        = mip_val & mie_q;
  assign irq_pending = |pend;
  assign csr_status  = mstatus_q;
  assign trap_taken  = trap_taken_q;
  assign trap_target = trap_target_q;

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .inhibit (minh_q[0]),
    .wen_lo  (csr_wen && csr_waddr == CSR_MCYCLE),
    .wen_hi  (csr_wen && csr_waddr == CSR_MCYCLEH),
    .wdata   (csr_wdata),
    .value   (cycle_val)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .inc     (instret),
    .inhibit (minh_q[2]),
    .wen_lo  (csr_wen && csr_waddr == CSR_MINSTRET),
    .wen_hi  (csr_wen && csr_waddr == CSR_MINSTRETH),
    .wdata   (csr_wdata),
    .value   (instret_val)
  );

  for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
    csr_counter64 u_hpm (
      .clk     (clk),
      .rst     (rst),
      .inc     (hpm_event[g]),
      .inhibit (minh_q[3+g]),
      .wen_lo  (csr_wen && csr_waddr == CSR_MHPMCOUNTER3 + 12'(g)),
      .wen_hi  (csr_wen && csr_waddr == CSR_MHPMCOUNTER3H + 12'(g)),
      .wdata   (csr_wdata),
      .value   (hpm_val[g])
    );
  end

  if (NUM_HPM == 0) begin : g_no_hpm
    assign hpm_val[0] = '0;
  end

  // Event arbitration: exception/ecall > interrupt > mret, decided on current state.
  always_comb begin
    ev        = EV_NONE;
    trap_code = 5'd0;
    if (exc_valid || ecall) begin
      ev        = EV_EXC;
      trap_code = exc_valid ? exc_cause : ecall_cause(priv_q);
    end else if (mstatus_q[MSTATUS_MIE] && irq_pending && int_ok) begin
      ev        = EV_IRQ;
      trap_code = irq_code(pend);
    end else if (mret) begin
      ev        = EV_MRET;
    end
  end

  // Software writes land first; trap/mret side effects then override their fields.
  always_comb begin
    mstatus_w  = mstatus_q;
    mie_d      = mie_q;
    mtvec_w    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_w     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    minh_d     = minh_q;
    if (csr_wen) begin
      case (csr_waddr)
        CSR_MSTATUS:       mstatus_w  = mstatus_legalize(csr_wdata);
        CSR_MIE:           mie_d      = csr_wdata & MIE_MASK;
        CSR_MTVEC:         mtvec_w    = csr_wdata & MTVEC_MASK;
        CSR_MSCRATCH:      mscratch_d = csr_wdata;
        CSR_MEPC:          mepc_w     = csr_wdata & MEPC_MASK;
        CSR_MCAUSE:        mcause_d   = csr_wdata & MCAUSE_MASK;
        CSR_MTVAL:         mtval_d    = csr_wdata;
        CSR_MCOUNTINHIBIT: minh_d     = csr_wdata & INH_MASK;
        default: ;
      endcase
    end

    mstatus_d     = mstatus_w;
    mtvec_d       = mtvec_w;
    mepc_d        = mepc_w;
    priv_d        = priv_q;
    trap_taken_d  = 1'b0;
    trap_target_d = 32'h0;
    tvec_base     = {mtvec_w[31:2], 2'b00};

    case (ev)
      EV_EXC, EV_IRQ: begin
        mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
        mstatus_d[MSTATUS_MIE]                   = 1'b0;
        priv_d        = PRIV_M;
        mepc_d        = ((ev == EV_IRQ) ? int_pc : exc_pc) & MEPC_MASK;
        mcause_d      = {(ev == EV_IRQ), 26'b0, trap_code};
        mtval_d       = (ev == EV_IRQ) ? 32'h0 : exc_tval;
        trap_taken_d  = 1'b1;
        trap_target_d = tvec_base;
        if (ev == EV_IRQ && mtvec_w[0])
          trap_target_d = tvec_base + {25'b0, trap_code, 2'b00};
      end
      EV_MRET: begin
        priv_d                                   = mstatus_w[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        mstatus_d[MSTATUS_MIE]                   = mstatus_w[MSTATUS_MPIE];
        mstatus_d[MSTATUS_MPIE]                  = 1'b1;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        trap_taken_d  = 1'b1;
        trap_target_d = mepc_w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q     <= '0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RST & MTVEC_MASK;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      minh_q        <= '0;
      priv_q        <= PRIV_M;
      trap_taken_q  <= 1'b0;
      trap_target_q <= '0;
    end else begin
      mstatus_q     <= mstatus_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      minh_q        <= minh_d;
      priv_q        <= priv_d;
      trap_taken_q  <= trap_taken_d;
      trap_target_q <= trap_target_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_ren) begin
      case (csr_raddr)
        CSR_MSTATUS:       csr_rdata = mstatus_q;
        CSR_MISA:          csr_rdata = MISA_VAL;
        CSR_MIE:           csr_rdata = mie_q;
        CSR_MTVEC:         csr_rdata = mtvec_q;
        CSR_MCOUNTINHIBIT: csr_rdata = minh_q;
        CSR_MSCRATCH:      csr_rdata = mscratch_q;
        CSR_MEPC:          csr_rdata = mepc_q;
        CSR_MCAUSE:        csr_rdata = mcause_q;
        CSR_MTVAL:         csr_rdata = mtval_q;
        CSR_MIP:           csr_rdata = mip_val;
        CSR_MCYCLE:        csr_rdata = cycle_val[31:0];
        CSR_MCYCLEH:       csr_rdata = cycle_val[63:32];
        CSR_MINSTRET:      csr_rdata = instret_val[31:0];
        CSR_MINSTRETH:     csr_rdata = instret_val[63:32];
        CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: csr_rdata = '0;
        default: begin
          for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_raddr == CSR_MHPMCOUNTER3 + 12'(i))  csr_rdata = hpm_val[i][31:0];
            if (csr_raddr == CSR_MHPMCOUNTER3H + 12'(i)) csr_rdata = hpm_val[i][63:32];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: redirect pulses go through a scoreboard
// queue, CSR state is compared inline in each scenario task.
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_status;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        ecall;
  logic        mret;
  logic        irq_ext, irq_soft, irq_timer;
  logic        int_ok;
  logic [31:0] int_pc;
  logic        instret;
  logic [3:0]  hpm_event;
  logic        trap_taken;
  logic [31:0] trap_target;
  logic        irq_pending;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #50 clk = ~clk;

  csr_trap_unit #(.NUM_HPM(4), .VECTORED_EN(1'b1), .MTVEC_RST(MTVEC_RST)) dut (
    .clk(clk), .rst(rst),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_status(csr_status),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .ecall(ecall), .mret(mret),
    .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
    .int_ok(int_ok), .int_pc(int_pc),
    .instret(instret), .hpm_event(hpm_event),
    .trap_taken(trap_taken), .trap_target(trap_target), .irq_pending(irq_pending)
  );

  // Advance one clock; the redirect seen after the edge must match the scoreboard head.
  task automatic cycle();
    logic [31:0] e;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (trap_taken !== 1'b1 || trap_target !== e) begin
        errors++;
        $display("FAIL trap_pulse taken=%0b target=%h, want taken=1 target=%h", trap_taken, trap_target, e);
      end
    end else if (trap_taken !== 1'b0 || trap_target !== 32'h0) begin
      errors++;
      $display("FAIL no_trap taken=%0b target=%h, want taken=0 target=0", trap_taken, trap_target);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
    cycle();
    csr_wen = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_ren = 1'b1; csr_raddr = a;
    #1;
    d = csr_rdata;
    csr_ren = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h1234; exc_tval = 32'h55;
    cycle();
    cycle();
    exc_valid = 1'b0;
    rst = 1'b0;
    csr_rd(12'h305, v); checks++;
    if (v !== MTVEC_RST) begin errors++; $display("FAIL reset_mtvec got=%h want=%h", v, MTVEC_RST); end
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_mcause got=%h want=0", v); end
    csr_rd(12'h341, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_mepc got=%h want=0", v); end
    csr_rd(12'hB00, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_mcycle got=%h want=0", v); end
    checks++;
    if (csr_status !== 32'h0) begin errors++; $display("FAIL reset_mstatus got=%h want=0", csr_status); end
    repeat (10) cycle();
    csr_rd(12'hB00, v); checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL mcycle_10 got=%0d want=10", v); end
    csr_rd(12'hF14, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mhartid got=%h want=0", v); end
    csr_raddr = 12'h305; #1; checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_ren got=%h want=0", csr_rdata); end
    csr_rd(12'h7C0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL unimpl_read got=%h want=0", v); end
  endtask

  task automatic test_irq_direct();
    logic [31:0] v;
    csr_wr(12'h305, 32'h100);
    csr_wr(12'h304, 32'h800);
    csr_wr(12'h300, 32'h8);
    csr_wr(12'h344, 32'h888);
    csr_rd(12'h344, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mip_sw_write got=%h want=0", v); end
    irq_ext = 1'b1; int_ok = 1'b0; int_pc = 32'h40;
    #1; checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_pending got=%0b want=1", irq_pending); end
    repeat (3) cycle();
    checks++;
    if (csr_status !== 32'h8) begin errors++; $display("FAIL held_pending_mstatus got=%h want=8", csr_status); end
    int_ok = 1'b1;
    exp_q.push_back(32'h100);
    cycle();
    irq_ext = 1'b0; int_ok = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got=%h want=8000000b", v); end
    csr_rd(12'h341, v); checks++;
    if (v !== 32'h40) begin errors++; $display("FAIL irq_mepc got=%h want=40", v); end
    csr_rd(12'h343, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL irq_mtval got=%h want=0", v); end
    checks++;
    if (csr_status !== 32'h1880) begin errors++; $display("FAIL irq_mstatus got=%h want=1880", csr_status); end
    cycle();
  endtask

  task automatic test_irq_vectored();
    logic [31:0] v;
    csr_wr(12'h305, 32'h101);
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h300, 32'h8);
    irq_timer = 1'b1; int_ok = 1'b1; int_pc = 32'h64;
    exp_q.push_back(32'h11C);
    cycle();
    irq_timer = 1'b0; int_ok = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h8000_0007) begin errors++; $display("FAIL mti_mcause got=%h want=80000007", v); end
    csr_wr(12'h304, 32'h888);
    csr_wr(12'h300, 32'h8);
    irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1; int_ok = 1'b1;
    exp_q.push_back(32'h12C);
    cycle();
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0; int_ok = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h8000_000B) begin errors++; $display("FAIL mei_prio_mcause got=%h want=8000000b", v); end
    csr_wr(12'h304, 32'h008);
    csr_wr(12'h300, 32'h8);
    irq_soft = 1'b1; irq_timer = 1'b1; int_ok = 1'b1;
    exp_q.push_back(32'h10C);
    cycle();
    irq_soft = 1'b0; irq_timer = 1'b0; int_ok = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h8000_0003) begin errors++; $display("FAIL msi_masked_mcause got=%h want=80000003", v); end
  endtask

  task automatic test_exc_vs_mret();
    logic [31:0] v;
    csr_wr(12'h300, 32'h8);
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD; mret = 1'b1;
    exp_q.push_back(32'h100);
    cycle();
    exc_valid = 1'b0; mret = 1'b0;
    csr_rd(12'h343, v); checks++;
    if (v !== 32'hDEAD) begin errors++; $display("FAIL exc_mtval got=%h want=dead", v); end
    csr_rd(12'h342, v); checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL exc_mcause got=%h want=2", v); end
    csr_rd(12'h341, v); checks++;
    if (v !== 32'h80) begin errors++; $display("FAIL exc_mepc got=%h want=80", v); end
    checks++;
    if (csr_status !== 32'h1880) begin errors++; $display("FAIL exc_mstatus got=%h want=1880", csr_status); end
  endtask

  task automatic test_mret_write();
    logic [31:0] v;
    csr_wr(12'h300, 32'h1880);
    csr_wen = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h203; mret = 1'b1;
    exp_q.push_back(32'h200);
    cycle();
    csr_wen = 1'b0; mret = 1'b0;
    checks++;
    if (csr_status !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h want=88", csr_status); end
    csr_rd(12'h341, v); checks++;
    if (v !== 32'h200) begin errors++; $display("FAIL mepc_align got=%h want=200", v); end
    ecall = 1'b1; exc_pc = 32'h10; exc_tval = 32'h0;
    exp_q.push_back(32'h100);
    cycle();
    ecall = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'd11) begin errors++; $display("FAIL ecall_m_cause got=%0d want=11", v); end
    checks++;
    if (csr_status !== 32'h1880) begin errors++; $display("FAIL ecall_m_mstatus got=%h want=1880", csr_status); end
    csr_wr(12'h300, 32'h0);
    csr_wr(12'h341, 32'h300);
    mret = 1'b1;
    exp_q.push_back(32'h300);
    cycle();
    mret = 1'b0;
    checks++;
    if (csr_status !== 32'h80) begin errors++; $display("FAIL mret_u_mstatus got=%h want=80", csr_status); end
    ecall = 1'b1; exc_pc = 32'h304;
    exp_q.push_back(32'h100);
    cycle();
    ecall = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL ecall_u_cause got=%0d want=8", v); end
    checks++;
    if (csr_status !== 32'h0) begin errors++; $display("FAIL ecall_u_mstatus got=%h want=0", csr_status); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h44; exc_tval = 32'h99;
    exp_q.push_back(32'h100);
    cycle();
    exc_valid = 1'b0; ecall = 1'b1; exc_pc = 32'h48; exc_tval = 32'h0;
    exp_q.push_back(32'h100);
    cycle();
    ecall = 1'b0;
    csr_rd(12'h342, v); checks++;
    if (v !== 32'd11) begin errors++; $display("FAIL b2b_mcause got=%0d want=11", v); end
    csr_rd(12'h341, v); checks++;
    if (v !== 32'h48) begin errors++; $display("FAIL b2b_mepc got=%h want=48", v); end
    cycle();
  endtask

  task automatic test_counters();
    logic [31:0] v, x, y, z;
    csr_wr(12'hB80, 32'h0);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_rd(12'hB00, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_load got=%h want=ffffffff", v); end
    csr_rd(12'hB80, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mcycleh_load got=%h want=0", v); end
    cycle();
    csr_rd(12'hB00, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo got=%h want=0", v); end
    csr_rd(12'hB80, v); checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi got=%h want=1", v); end
    csr_wr(12'hB80, 32'hFFFF_FFFF);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    cycle();
    csr_rd(12'hB00, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL wrap64_lo got=%h want=0", v); end
    csr_rd(12'hB80, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL wrap64_hi got=%h want=0", v); end
    csr_rd(12'hB02, y);
    instret = 1'b1;
    repeat (3) cycle();
    instret = 1'b0;
    csr_rd(12'hB02, v); checks++;
    if (v !== y + 32'd3) begin errors++; $display("FAIL minstret_count got=%0d want=%0d", v, y + 32'd3); end
    csr_wr(12'h320, 32'h5);
    csr_rd(12'h320, v); checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL mcountinhibit got=%h want=5", v); end
    csr_rd(12'hB00, x);
    csr_rd(12'hB02, y);
    csr_rd(12'hB03, z);
    instret = 1'b1; hpm_event = 4'b0001;
    repeat (5) cycle();
    instret = 1'b0; hpm_event = 4'b0000;
    csr_rd(12'hB00, v); checks++;
    if (v !== x) begin errors++; $display("FAIL mcycle_inhibit got=%0d want=%0d", v, x); end
    csr_rd(12'hB02, v); checks++;
    if (v !== y) begin errors++; $display("FAIL minstret_inhibit got=%0d want=%0d", v, y); end
    csr_rd(12'hB03, v); checks++;
    if (v !== z + 32'd5) begin errors++; $display("FAIL hpm3_count got=%0d want=%0d", v, z + 32'd5); end
  endtask

  initial begin
    rst = 1'b1;
    csr_wen = 1'b0; csr_waddr = '0; csr_wdata = '0;
    csr_ren = 1'b0; csr_raddr = '0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    ecall = 1'b0; mret = 1'b0;
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
    int_ok = 1'b0; int_pc = '0;
    instret = 1'b0; hpm_event = '0;

    test_reset();
    test_irq_direct();
    test_irq_vectored();
    test_exc_vs_mret();
    test_mret_write();
    test_back_to_back();
    test_counters();
    repeat (2) cycle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
